// File: rtl/shifter_collector.sv
// ---------------------------------------------------------------------------
// shifter_collector
//
// Receive-side partner of the load/shift serializer. Collects nBits-wide
// words one per cycle and packs them into an M-bit vector. The first word
// received ends up in the top slice, which matches the serializer's word
// order. A complete vector is offered on a valid/ready handshake. A flush
// request zero-pads a partially filled vector so it can still be delivered.
//
// Ports:
//   clock       sole clock, all state updates on its rising edge
//   reset       asynchronous active-high reset
//   clear       synchronous clear, beats every other input
//   in_valid    Data_in carries a word this cycle
//   Data_in     incoming word
//   flush       request to emit the partial vector, zero-padded
//   out_ready   consumer takes Data_out this cycle
//   in_ready    collector accepts a word this cycle
//   out_valid   Data_out holds a complete vector
//   Data_out    assembled vector, top slice = first word
//   word_count  slices filled so far, 0..N
//   overrun     sticky flag: a word was offered while in_ready was low
// ---------------------------------------------------------------------------
module shifter_collector #(
  parameter  int M     = 128,
  parameter  int nBits = 32,
  localparam int N     = M / nBits,
  localparam int CW    = $clog2(M / nBits) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [nBits-1:0] Data_in,
  input  logic             flush,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic [M-1:0]     Data_out,
  output logic [CW-1:0]    word_count,
  output logic             overrun
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_PAD     = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [CW-1:0] COUNT_FULL = CW'(N);

  logic [1:0]    state_q,   state_d;
  logic [M-1:0]  data_q,    data_d;
  logic [CW-1:0] count_q,   count_d;
  logic          overrun_q, overrun_d;

  // Word count after this cycle's accept, used so that a flush arriving
  // together with a word sees the word already counted.
  logic [CW-1:0] count_inc;

  assign count_inc = count_q + CW'(1);

  // Handshake outputs come straight from the registered state so neither
  // ready nor valid has a combinational path from any input.
  assign in_ready   = (state_q == ST_COLLECT);
  assign out_valid  = (state_q == ST_FULL);
  assign Data_out   = data_q;
  assign word_count = count_q;
  assign overrun    = overrun_q;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (clear) begin
      state_d   = ST_COLLECT;
      data_d    = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      // A word offered while we cannot take it is dropped and remembered.
      if (in_valid && !in_ready) begin
        overrun_d = 1'b1;
      end

      case (state_q)
        ST_COLLECT: begin
          if (in_valid) begin
            data_d  = {data_q[M-nBits-1:0], Data_in};
            count_d = count_inc;
            if (count_inc == COUNT_FULL) begin
              state_d = ST_FULL;
            end else if (flush) begin
              state_d = ST_PAD;
            end
          end else if (flush && (count_q != '0)) begin
            state_d = ST_PAD;
          end
        end

        // Shift in one zero word per cycle until the vector is full.
        ST_PAD: begin
          data_d  = {data_q[M-nBits-1:0], {nBits{1'b0}}};
          count_d = count_inc;
          if (count_inc == COUNT_FULL) begin
            state_d = ST_FULL;
          end
        end

        ST_FULL: begin
          if (out_ready) begin
            state_d = ST_COLLECT;
            data_d  = '0;
            count_d = '0;
          end
        end

        default: begin
          state_d = ST_COLLECT;
          data_d  = '0;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_COLLECT;
      data_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_shifter_collector.sv
// ---------------------------------------------------------------------------
// tb_shifter_collector
//
// Self-checking bench for shifter_collector (M=128, nBits=32, N=4). A
// behavioural model keeps the collected words in a queue and derives the
// expected outputs from it; each scenario task compares DUT outputs against
// the model and against fixed vectors.
// ---------------------------------------------------------------------------
module tb_shifter_collector;

  localparam int M     = 128;
  localparam int nBits = 32;
  localparam int N     = M / nBits;
  localparam int CW    = $clog2(N) + 1;
  localparam int OW    = 3 + CW + M;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             in_valid;
  logic [nBits-1:0] Data_in;
  logic             flush;
  logic             out_ready;
  logic             in_ready;
  logic             out_valid;
  logic [M-1:0]     Data_out;
  logic [CW-1:0]    word_count;
  logic             overrun;

  int n_checks = 0;
  int n_fails  = 0;

  shifter_collector #(.M(M), .nBits(nBits)) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .Data_in    (Data_in),
    .flush      (flush),
    .out_ready  (out_ready),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .Data_out   (Data_out),
    .word_count (word_count),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Behavioural model: the words held so far (padding zeros included),
  // plus whether a vector is on offer, whether padding is underway, and
  // the sticky overrun flag.
  logic [nBits-1:0] m_words[$];
  bit m_full;
  bit m_pad;
  bit m_ovr;

  function automatic void model_reset();
    m_words.delete();
    m_full = 1'b0;
    m_pad  = 1'b0;
    m_ovr  = 1'b0;
  endfunction

  function automatic void model_step(bit iv, logic [nBits-1:0] d, bit fl, bit ordy, bit clr);
    if (clr) begin
      model_reset();
      return;
    end
    if (iv && (m_full || m_pad)) m_ovr = 1'b1;
    if (m_full) begin
      if (ordy) begin
        m_full = 1'b0;
        m_words.delete();
      end
    end else if (m_pad) begin
      m_words.push_back('0);
      if (m_words.size() == N) begin
        m_pad  = 1'b0;
        m_full = 1'b1;
      end
    end else begin
      if (iv) m_words.push_back(d);
      if (m_words.size() == N) m_full = 1'b1;
      else if (fl && m_words.size() > 0) m_pad = 1'b1;
    end
  endfunction

  // Expected vector: the words read oldest-first as one big number.
  function automatic logic [M-1:0] model_vec();
    logic [M-1:0] v = '0;
    foreach (m_words[i]) v = (v << nBits) | M'(m_words[i]);
    return v;
  endfunction

  function automatic logic [OW-1:0] exp_obs();
    return {!(m_full || m_pad), m_full, m_ovr, CW'(m_words.size()), model_vec()};
  endfunction

  function automatic logic [OW-1:0] dut_obs();
    return {in_ready, out_valid, overrun, word_count, Data_out};
  endfunction

  // One clock of stimulus; the model advances on the same edge and the
  // outputs are sampled 1 time unit later.
  task automatic drive(bit iv, logic [nBits-1:0] d, bit fl, bit ordy, bit clr);
    in_valid  = iv;
    Data_in   = d;
    flush     = fl;
    out_ready = ordy;
    clear     = clr;
    @(posedge clock);
    model_step(iv, d, fl, ordy, clr);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 0; in_valid = 0; Data_in = '0; flush = 0; out_ready = 0;
    model_reset();
    #12;
    n_checks++;
    if ({out_valid, overrun, word_count, Data_out} !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, overrun, word_count, Data_out});
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_full_vector();
    logic [M-1:0] want = 128'h11111111_22222222_33333333_44444444;
    for (int i = 1; i <= 4; i++) begin
      drive(1, {8{4'(i)}}, 0, 0, 0);
      n_checks++;
      if (dut_obs() !== exp_obs()) begin
        n_fails++;
        $display("[TB] FAIL full_word%0d: got %h expected %h", i, dut_obs(), exp_obs());
      end
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (!out_valid || Data_out !== want || word_count !== CW'(N)) begin
        n_fails++;
        $display("[TB] FAIL full_hold%0d: got v=%b d=%h c=%0d expected v=1 d=%h c=%0d",
                 i, out_valid, Data_out, word_count, want, N);
      end
      drive(0, '0, 0, 0, 0);
    end
  endtask

  task automatic test_handshake();
    logic [M-1:0] want = 128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004;
    drive(0, '0, 0, 1, 0);
    n_checks++;
    if ({out_valid, in_ready, word_count, Data_out} !== {1'b0, 1'b1, {CW{1'b0}}, {M{1'b0}}}) begin
      n_fails++;
      $display("[TB] FAIL handshake_release: got %h expected %h",
               {out_valid, in_ready, word_count, Data_out}, {1'b0, 1'b1, {CW{1'b0}}, {M{1'b0}}});
    end
    for (int i = 1; i <= 4; i++) drive(1, 32'hCAFE0000 + 32'(i), 0, 0, 0);
    n_checks++;
    if (!out_valid || Data_out !== want || dut_obs() !== exp_obs()) begin
      n_fails++;
      $display("[TB] FAIL handshake_second: got %h expected %h", Data_out, want);
    end
    drive(0, '0, 0, 1, 0);
  endtask

  task automatic test_flush();
    logic [M-1:0] want = 128'hAAAAAAAA_BBBBBBBB_00000000_00000000;
    drive(1, 32'hAAAAAAAA, 0, 0, 0);
    drive(1, 32'hBBBBBBBB, 0, 0, 0);
    drive(0, '0, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || dut_obs() !== exp_obs()) begin
        n_fails++;
        $display("[TB] FAIL flush_pad%0d: got %h expected %h", i, dut_obs(), exp_obs());
      end
      drive(0, '0, 0, 0, 0);
    end
    n_checks++;
    if (out_valid !== 1'b1 || Data_out !== want) begin
      n_fails++;
      $display("[TB] FAIL flush_vector: got v=%b d=%h expected v=1 d=%h", out_valid, Data_out, want);
    end
    drive(0, '0, 0, 1, 0);
    // Flush with the last word completes the vector directly.
    for (int i = 1; i <= 3; i++) drive(1, 32'h0000F000 + 32'(i), 0, 0, 0);
    drive(1, 32'h0000F004, 1, 0, 0);
    n_checks++;
    if (out_valid !== 1'b1 || Data_out !== 128'h0000F001_0000F002_0000F003_0000F004) begin
      n_fails++;
      $display("[TB] FAIL flush_last_word: got v=%b d=%h expected v=1", out_valid, Data_out);
    end
    // Flush on an empty collector must be ignored.
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 1, 0, 0);
    n_checks++;
    if (in_ready !== 1'b1 || word_count !== '0 || dut_obs() !== exp_obs()) begin
      n_fails++;
      $display("[TB] FAIL flush_empty: got %h expected %h", dut_obs(), exp_obs());
    end
  endtask

  task automatic test_overrun();
    logic [M-1:0] want = 128'h01010101_02020202_03030303_04040404;
    for (int i = 1; i <= 4; i++) drive(1, {4{8'(i)}}, 0, 0, 0);
    drive(1, 32'hDEADBEEF, 0, 0, 0);
    n_checks++;
    if (overrun !== 1'b1 || Data_out !== want || out_valid !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL overrun_set: got o=%b d=%h expected o=1 d=%h", overrun, Data_out, want);
    end
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 0, 0);
    n_checks++;
    if (overrun !== 1'b1 || dut_obs() !== exp_obs()) begin
      n_fails++;
      $display("[TB] FAIL overrun_sticky: got %h expected %h", dut_obs(), exp_obs());
    end
    drive(0, '0, 0, 0, 1);
    n_checks++;
    if (overrun !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h12345678, 0, 0, 0);
    drive(1, 32'h9ABCDEF0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({out_valid, overrun, word_count, Data_out} !== '0) begin
      n_fails++;
      $display("[TB] FAIL async_reset: got %h expected 0", {out_valid, overrun, word_count, Data_out});
    end
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1, 32'h50000000 + 32'(i), 0, 0, 0);
    n_checks++;
    if (Data_out !== 128'h50000000_50000001_50000002_50000003 || out_valid !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL async_reset_burst: got v=%b d=%h", out_valid, Data_out);
    end
    drive(0, '0, 0, 1, 0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) drive(1, 32'h77770000 + 32'(i), 0, 0, 0);
    drive(1, 32'h7777FFFF, 1, 0, 1);
    n_checks++;
    if ({in_ready, out_valid, word_count, Data_out} !== {1'b1, 1'b0, {CW{1'b0}}, {M{1'b0}}}) begin
      n_fails++;
      $display("[TB] FAIL clear_mid: got %h expected %h",
               {in_ready, out_valid, word_count, Data_out}, {1'b1, 1'b0, {CW{1'b0}}, {M{1'b0}}});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(99) < 60, $urandom, $urandom_range(99) < 10,
            $urandom_range(99) < 30, $urandom_range(99) < 3);
      n_checks++;
      if (dut_obs() !== exp_obs()) begin
        n_fails++;
        $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, dut_obs(), exp_obs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_handshake();
    test_flush();
    test_overrun();
    test_async_reset();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
